cfg_width_arbiter: RTL
======================

# cfg_width_arbiter

Arbitrates configuration writes from two requesters onto a single narrow configuration register. Each request carries a DW-bit value, and the block checks that the value fits in the register's WIDTH bits. Values that fit are committed. Values that would lose significant bits are rejected and counted, never silently truncated. The block sits between wide software-facing config sources and a narrow-parameterised consumer, for example a 1-bit mode select.

## Interface
- WIDTH, 1: width of the configuration register; legal range 1..DW.
- DW, 32: width of each requester's write data.
- RESET_VAL, 0: WIDTH-bit value loaded into cfg_out on reset.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- req  in  2  per-requester write request; level, held until the matching ack or nack.
- wdata0  in  DW  requester 0 write value; must be stable while req[0] is high.
- wdata1  in  DW  requester 1 write value; must be stable while req[1] is high.
- ack  out  2  one-cycle pulse: request committed.
- nack  out  2  one-cycle pulse: request rejected (value overflows WIDTH).
- cfg_out  out  WIDTH  current configuration value.
- cfg_upd  out  1  one-cycle pulse, coincident with ack, when cfg_out is written.
- err_sticky  out  1  set on any reject; cleared by err_clr.
- err_cnt  out  8  saturating reject count.
- err_clr  in  1  synchronous clear of err_sticky and err_cnt.

## Operation
- FSM states: IDLE, CHECK, RESP, WAIT. Reset state is IDLE.
- IDLE:
  - If req is nonzero: pick a winner, latch its index and wdata, move to CHECK.
  - Otherwise stay in IDLE.
- Arbitration is round-robin over a 1-bit last-grant pointer (rr_last).
  - Single request: granted directly.
  - Both requesting: grant the requester that is not rr_last.
  - rr_last is updated on every grant and resets to 1, so requester 0 wins the first tie.
- CHECK:
  - fits = (latched_data[DW-1:WIDTH] == 0). When WIDTH == DW, fits = 1.
  - Then move to RESP.
- RESP, registered outputs active for exactly this cycle:
  - fits: ack[winner]=1, cfg_upd=1, cfg_out <= latched_data[WIDTH-1:0].
  - not fits: nack[winner]=1, cfg_out unchanged, err_sticky <= 1, err_cnt <= err_cnt+1 (saturating at 255).
  - Then move to WAIT.
- WAIT: one idle cycle. The serviced requester must have dropped req by this cycle. Then move to IDLE.
- A req that is raised or dropped mid-transaction by the non-winning requester does not affect the current transaction.
- err_clr high at a clock edge:
  - Sets err_sticky to 0 and err_cnt to 0.
  - If a reject is registered on the same edge, the result is err_sticky=1 and err_cnt=1.
- At most one of ack/nack is high in any cycle, and never for both requesters.

## Timing
- Reset values:
  - state = IDLE, rr_last = 1.
  - ack = 0, nack = 0, cfg_upd = 0.
  - cfg_out = RESET_VAL, err_sticky = 0, err_cnt = 0.
- Reset asserted mid-transaction: the transaction is dropped with no ack or nack, and outputs take their reset values immediately.
- Latency:
  - req sampled high at edge E0 (IDLE→CHECK).
  - E1: enters RESP; ack/nack/cfg_upd high and cfg_out new from E1 until E2.
  - E2: WAIT. E3: IDLE.
  - Earliest next grant sample is E4, giving a sustained throughput of 1 transaction per 4 cycles.
- The requester observes ack/nack during E1..E2 and deasserts req before E3.

## Test plan
- WIDTH=1, wdata0=32'd0 then 32'd1, one request each:
  - Both acked; cfg_out goes 0 then 1.
  - cfg_upd pulses twice; err_cnt stays 0.
- WIDTH=1, wdata0=32'd2:
  - nack[0] pulses at E1; cfg_out unchanged.
  - err_sticky=1, err_cnt=1, no cfg_upd.
- Both req high from reset with wdata0=0, wdata1=1, each re-requesting immediately after service:
  - Grants alternate 0,1,0,1.
  - Each ack arrives exactly 4 cycles after the previous one.
- 260 consecutive overflowing writes, then err_clr asserted on the same edge as the 261st reject:
  - err_cnt saturates at 255.
  - After the clear, err_cnt=1 and err_sticky=1.
- rst_n pulsed low during CHECK of a write of 1 (WIDTH=1, RESET_VAL=0):
  - No ack/nack; cfg_out=0.
  - The next request is serviced normally.
- WIDTH=DW=32, wdata1=32'hFFFF_FFFF: acked; cfg_out=32'hFFFF_FFFF.

Source files
------------

// File: rtl/cfg_width_arbiter_if.sv
// Bundle between the two config requesters and cfg_width_arbiter.
// req[i] is a level held until ack[i] or nack[i] pulses for one cycle; wdata must be stable while req is high.
interface cfg_width_arbiter_if #(
    parameter int DW    = 32,
    parameter int WIDTH = 1
);
    logic [1:0]       req;
    logic [DW-1:0]    wdata0;
    logic [DW-1:0]    wdata1;
    logic [1:0]       ack;
    logic [1:0]       nack;
    logic [WIDTH-1:0] cfg_out;
    logic             cfg_upd;
    logic             err_sticky;
    logic [7:0]       err_cnt;
    logic             err_clr;
    logic [1:0]       dbg_state;

    modport master (
        output req, wdata0, wdata1, err_clr,
        input  ack, nack, cfg_out, cfg_upd, err_sticky, err_cnt, dbg_state
    );

    modport slave (
        input  req, wdata0, wdata1, err_clr,
        output ack, nack, cfg_out, cfg_upd, err_sticky, err_cnt, dbg_state
    );
endinterface

// File: rtl/cfg_width_arbiter.sv
// Round-robin arbiter of two config writers onto a WIDTH-bit register.
// Writes whose value does not fit in WIDTH bits are rejected and counted instead of truncated.
module cfg_width_arbiter #(
    parameter int               WIDTH     = 1,
    parameter int               DW        = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    cfg_width_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            rr_last;
    logic            win;
    logic            grant;
    logic [DW-1:0]   lat_data;
    logic            fits;
    logic            reject;
    logic [1:0]      win_onehot;

    // Ties go to whichever requester was not granted last.
    always_comb begin
        grant = 1'b0;
        case (bus.req)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~rr_last;
            default: grant = 1'b0;
        endcase
    end

    // Shifting by WIDTH leaves zero when WIDTH == DW, so full-width writes always fit.
    assign fits       = ((lat_data >> WIDTH) == '0);
    assign reject     = (state == CHECK) && !fits;
    assign win_onehot = win ? 2'b10 : 2'b01;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.req != 2'b00) state_nx = CHECK;
            CHECK:   state_nx = RESP;
            RESP:    state_nx = WAIT;
            WAIT:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_last  <= 1'b1;
            win      <= 1'b0;
            lat_data <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.req != 2'b00) begin
                win      <= grant;
                rr_last  <= grant;
                lat_data <= grant ? bus.wdata1 : bus.wdata0;
            end
        end
    end

    // Response outputs are registered on the CHECK->RESP edge, so they are high exactly during RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ack     <= '0;
            bus.nack    <= '0;
            bus.cfg_upd <= 1'b0;
            bus.cfg_out <= RESET_VAL;
        end else begin
            bus.ack     <= '0;
            bus.nack    <= '0;
            bus.cfg_upd <= 1'b0;
            if (state == CHECK) begin
                if (fits) begin
                    bus.ack     <= win_onehot;
                    bus.cfg_upd <= 1'b1;
                    bus.cfg_out <= lat_data[WIDTH-1:0];
                end else begin
                    bus.nack    <= win_onehot;
                end
            end
        end
    end

    // A reject landing on the same edge as a clear wins, leaving a count of one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.err_sticky <= 1'b0;
            bus.err_cnt    <= '0;
        end else if (bus.err_clr || reject) begin
            bus.err_sticky <= reject;
            if (bus.err_clr)
                bus.err_cnt <= {7'd0, reject};
            else if (bus.err_cnt != 8'hFF)
                bus.err_cnt <= bus.err_cnt + 8'd1;
        end
    end

    assign bus.dbg_state = state;

endmodule
